uart_tx_fifo: RTL and testbench

Buffered UART transmitter that drives the SoC `UART_TX` pin. It accepts bytes from the MMIO UART register decoder through a valid/ready write port and queues them in a small FIFO. It serialises each byte as an 8N1 frame at a fixed baud rate derived from the system clock. Its output is the line decoded by `uart_baud_monitor` in simulation runs.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_tx_fifo.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and helpers for the transmitter and the
//               simulation-side baud monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Clocks per bit, truncated; widened so large MHz values cannot overflow.
    function automatic int uart_divisor(input int clk_freq_mhz, input int baud_rate);
        longint hz;
        hz = longint'(clk_freq_mhz) * 64'd1_000_000;
        return int'(hz / longint'(baud_rate));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, power-of-two depth, occupancy count.
//               A push is refused while full even if a pop happens alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Pointers wrap naturally; full/empty come only from the count.
    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered 8N1 UART transmitter with a write-side FIFO.
//               Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 27,
    parameter int BAUD_RATE    = 115200,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_valid,
    input  logic [7:0]                      wr_data,
    output logic                            wr_ready,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            uart_tx
);

    localparam int DIVISOR = uart_divisor(CLK_FREQ_MHZ, BAUD_RATE);
    localparam int BAUD_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(DIVISOR - 1);
    localparam logic [2:0]        C_BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t   r_state;
    uart_tx_state_t   w_next_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              w_pop;
    logic              w_baud_done;
    logic              w_last_bit;
    logic [7:0]        w_fifo_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign w_baud_done = (r_baud_cnt == C_BAUD_LAST);
    assign w_last_bit  = (r_bit_cnt == C_BIT_LAST);

    assign wr_ready   = !w_fifo_full;
    assign fifo_count = w_fifo_count;
    assign busy       = (r_state != IDLE) || (w_fifo_count != '0);
    assign uart_tx    = r_tx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_next_state = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_baud_done && w_last_bit) begin
`ifdef UART_TX_PARITY_EN
                    w_next_state = PARITY;
`else
                    w_next_state = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_baud_done) begin
                    w_next_state = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (w_baud_done) begin
                    w_next_state = w_fifo_empty ? IDLE : START;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_pop        = 1'b0;
        w_shift_next = r_shift;
        w_tx_next    = 1'b1;
        if (!w_fifo_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_done))) begin
            w_pop = 1'b1;
        end
        if ((r_state == DATA) && w_baud_done && !w_last_bit) begin
            w_shift_next = {1'b0, r_shift[7:1]};
        end
        // The line value is chosen from the upcoming state so it is registered glitch-free.
        case (w_next_state)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = r_parity;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_tx <= w_tx_next;
            if ((r_state == IDLE) || w_baud_done) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
            end
            if (r_state != DATA) begin
                r_bit_cnt <= '0;
            end else if (w_baud_done) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_pop) begin
                r_shift  <= w_fifo_data;
`ifdef UART_TX_PARITY_EN
                r_parity <= ^w_fifo_data;
`endif
            end else begin
                r_shift <= w_shift_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo (default
//               parameters; follows UART_TX_PARITY_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DIV = 234;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * DIV;
    localparam int HALF  = DIV / 2;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // {stop, d7..d0, start}
        logic       parity;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;
    logic [3:0] fifo_count;
    logic       uart_tx;

    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned reset_cnt = 0;
    logic        track_en = 1'b0;
    logic [3:0]  max_count = '0;
    logic [7:0]  rx_q[$];
    int unsigned rx_t[$];

    uart_tx_fifo #(
        .CLK_FREQ_MHZ (27),
        .BAUD_RATE    (115200),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .fifo_count (fifo_count),
        .uart_tx    (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) reset_cnt <= reset_cnt + 1;
    end

    always @(negedge clk) begin
        if (!track_en) max_count <= '0;
        else if (fifo_count > max_count) max_count <= fifo_count;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line decoder: samples mid-bit, drops frames cut short by reset.
    initial begin : line_monitor
        logic        prev;
        logic [10:0] bits;
        int unsigned rc0;
        int unsigned t0;
        logic        good;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && prev && (uart_tx === 1'b0)) begin
                t0   = cyc;
                rc0  = reset_cnt;
                bits = '1;
                for (int off = 1; off < FRAME; off++) begin
                    if (off == HALF) bits[0] = uart_tx;
                    @(negedge clk);
                    if (reset_cnt != rc0) break;
                    if ((off % DIV) == HALF) bits[off / DIV] = uart_tx;
                end
                good = (reset_cnt == rc0) && !bits[0] && bits[NB-1];
`ifdef UART_TX_PARITY_EN
                good = good && (bits[9] == ^bits[8:1]);
`endif
                if (good) begin
                    rx_q.push_back(bits[8:1]);
                    rx_t.push_back(t0);
                end
            end
            prev = (uart_tx === 1'b1);
        end
    end

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (busy && (n < bound)) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (n < bound), 1);
    endtask

    // Write one byte into an idle block and check every bit's first and last cycle.
    task automatic check_frame(input vec_t v);
        logic [10:0] seq;
`ifdef UART_TX_PARITY_EN
        seq = {v.frame[9], v.parity, v.frame[8:0]};
`else
        seq = {1'b0, v.frame};
`endif
        wr_valid = 1'b1;
        wr_data  = v.data;
        @(negedge clk);
        wr_valid = 1'b0;
        check($sformatf("v%02h_prefall", v.data), uart_tx, 1);
        check($sformatf("v%02h_count1", v.data), fifo_count, 1);
        check($sformatf("v%02h_busy_q", v.data), busy, 1);
        @(negedge clk);
        check($sformatf("v%02h_popped", v.data), fifo_count, 0);
        for (int k = 0; k < NB; k++) begin
            check($sformatf("v%02h_b%0d_first", v.data, k), uart_tx, seq[k]);
            repeat (DIV - 1) @(negedge clk);
            check($sformatf("v%02h_b%0d_last", v.data, k), uart_tx, seq[k]);
            if (k == NB - 1) check($sformatf("v%02h_busy_end", v.data), busy, 1);
            @(negedge clk);
        end
        check($sformatf("v%02h_idle", v.data), busy, 0);
        check($sformatf("v%02h_line_hi", v.data), uart_tx, 1);
    endtask

    initial begin
        vec_t       vecs[5];
        vec_t       v55;
        int         n;
        logic [7:0] b;

        vecs[0] = '{8'h41, 10'b1_01000001_0, 1'b0};
        vecs[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
        vecs[2] = '{8'h03, 10'b1_00000011_0, 1'b0};
        vecs[3] = '{8'h80, 10'b1_10000000_0, 1'b1};
        vecs[4] = '{8'hFF, 10'b1_11111111_0, 1'b0};
        v55     = '{8'h55, 10'b1_01010101_0, 1'b0};

        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", uart_tx, 1);
        check("rst_ready", wr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) check_frame(vecs[i]);
        check("mon_count", rx_q.size(), 5);
        check("mon_A", rx_q[0], 8'h41);

        // "Hi" on consecutive cycles: two frames, no gap.
        rx_q.delete();
        rx_t.delete();
        wr_valid = 1'b1;
        wr_data  = 8'h48;
        @(negedge clk);
        wr_data  = 8'h69;
        @(negedge clk);
        wr_valid = 1'b0;
        wait_idle(3 * FRAME, n);
        check("hi_duration", n, 2 * FRAME);
        check("hi_count", rx_q.size(), 2);
        check("hi_H", rx_q[0], 8'h48);
        check("hi_i", rx_q[1], 8'h69);
        check("hi_gap", rx_t[1] - rx_t[0], FRAME);

        // Fill to full with 0x00 first, drop a 10th write, then reset mid-frame.
        rx_q.delete();
        wr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_data = 8'(i * 8'h11);
            @(negedge clk);
        end
        check("fill_count", fifo_count, 8);
        check("fill_ready", wr_ready, 0);
        wr_data = 8'h99;
        @(negedge clk);
        wr_valid = 1'b0;
        check("drop_count", fifo_count, 8);
        check("drop_tx_start", uart_tx, 0);
        repeat (991) @(negedge clk);
        check("pre_reset_tx", uart_tx, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_tx", uart_tx, 1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", wr_ready, 1);
        repeat (2) @(negedge clk);
        check_frame(v55);
        check("post_rst_rx_n", rx_q.size(), 1);
        check("post_rst_rx", rx_q[0], 8'h55);

        // Hold wr_valid through 16 distinct bytes from an idle block.
        rx_q.delete();
        track_en = 1'b1;
        @(negedge clk);
        wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i * 29) ^ 8'hC3;
            if (i == 9) begin
                check("held_full_ready", wr_ready, 0);
                check("held_full_count", fifo_count, 8);
            end
            n = 0;
            while (!wr_ready && (n < 2 * FRAME)) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("held_wait_%0d", i), (n < 2 * FRAME), 1);
            if (i < 9) check($sformatf("held_immediate_%0d", i), n, 0);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        wait_idle(10 * FRAME, n);
        @(negedge clk);
        check("held_max_count", max_count, 8);
        track_en = 1'b0;
        check("held_rx_n", rx_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 29) ^ 8'hC3;
            check($sformatf("held_rx_%0d", i), rx_q[i], b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
